morph_filter_nxn: RTL and testbench

Parametrised grey-scale morphology engine. Successor to the fixed 3x3 dilate/erode block in the camera/UDP video path. Consumes the raster grey stream (`gray_val_s1` domain, `data_en` qualified) and buffers `KSIZE-1` lines internally in inferred BRAM. Outputs one selectable result per accepted pixel: dilate, erode, morphological gradient or delayed passthrough, with frame-aligned valid and end-of-frame flags.

---
 rtl/morph_filter_nxn.sv | 318 +++++++++++++++++++++++++++++++
 tb/tb_morph_filter_nxn.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/morph_filter_nxn.sv
// -----------------------------------------------------------------------------
// morph_filter_nxn
// Grey-scale morphology engine with a KSIZE x KSIZE window anchored at the
// bottom-right on each accepted pixel. The window replicates the top and left
// edges. It produces dilate, erode, gradient or passthrough with a fixed
// 3-cycle latency. KSIZE-1 line RAMs are written in rotation, one line each.
//
// Optional feature macro: MORPH_THRESH_EN adds `thresh` / `out_bin`.
//
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   in_valid   pixel strobe (gaps allowed)
//   in_sof     start of frame, qualified by in_valid, marks pixel (0,0)
//   in_pixel   grey input pixel
//   mode       00 dilate, 01 erode, 10 gradient, 11 passthrough (latched at sof)
//   thresh     (MORPH_THRESH_EN) binarisation threshold, latched at sof
//   out_bin    (MORPH_THRESH_EN) result >= thresh
//   out_valid  result strobe, in_valid delayed by 3 cycles
//   out_pixel  result pixel
//   out_eof    high with out_valid on the last pixel of the frame
// -----------------------------------------------------------------------------
module morph_filter_nxn #(
  parameter int DATA_WIDTH = 8,
  parameter int IMG_WIDTH  = 640,
  parameter int IMG_HEIGHT = 480,
  parameter int KSIZE      = 3
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  input  logic                  in_sof,
  input  logic [DATA_WIDTH-1:0] in_pixel,
  input  logic [1:0]            mode,
`ifdef MORPH_THRESH_EN
  input  logic [DATA_WIDTH-1:0] thresh,
  output logic                  out_bin,
`endif
  output logic                  out_valid,
  output logic [DATA_WIDTH-1:0] out_pixel,
  output logic                  out_eof
);

  localparam int NRAM = KSIZE - 1;
  localparam int XW   = (IMG_WIDTH  > 1) ? $clog2(IMG_WIDTH)  : 1;
  localparam int YW   = (IMG_HEIGHT > 1) ? $clog2(IMG_HEIGHT) : 1;
  localparam int SW   = (NRAM > 1) ? $clog2(NRAM) : 1;

  localparam logic [XW-1:0] X_LAST = XW'(IMG_WIDTH - 1);
  localparam logic [YW-1:0] Y_LAST = YW'(IMG_HEIGHT - 1);
  localparam logic [XW-1:0] X_ONE  = XW'(1);
  localparam logic [YW-1:0] Y_ONE  = YW'(1);
  localparam logic [SW-1:0] S_LAST = SW'(NRAM - 1);
  localparam logic [SW-1:0] S_ONE  = SW'(1);

  localparam logic [1:0] MODE_DILATE = 2'b00;
  localparam logic [1:0] MODE_ERODE  = 2'b01;
  localparam logic [1:0] MODE_GRAD   = 2'b10;
  localparam logic [1:0] MODE_PASS   = 2'b11;

  if (KSIZE != 3 && KSIZE != 5) begin : g_bad_ksize
    $error("morph_filter_nxn: KSIZE must be 3 or 5");
  end

  // ---------------------------------------------------------------------------
  // Position counters, line-RAM select and frame-latched controls
  // ---------------------------------------------------------------------------
  logic [XW-1:0]         x_q, x_d, px_s;
  logic [YW-1:0]         y_q, y_d, py_s;
  logic [SW-1:0]         wsel_q, wsel_d, wsel_s;
  logic [1:0]            mode_q, mode_d;
  logic [DATA_WIDTH-1:0] thr_q, thr_d;
  logic                  last_col_s, last_row_s;

  // Current pixel position (sof forces 0,0) and next counter state.
  always_comb begin
    px_s       = in_sof ? '0 : x_q;
    py_s       = in_sof ? '0 : y_q;
    wsel_s     = in_sof ? '0 : wsel_q;
    last_col_s = (px_s == X_LAST);
    last_row_s = (py_s == Y_LAST);
    x_d        = x_q;
    y_d        = y_q;
    wsel_d     = wsel_q;
    if (in_valid) begin
      if (last_col_s) begin
        x_d = '0;
        if (last_row_s) begin
          y_d    = '0;
          wsel_d = '0;
        end else begin
          y_d    = py_s + Y_ONE;
          wsel_d = (wsel_s == S_LAST) ? '0 : wsel_s + S_ONE;
        end
      end else begin
        x_d    = px_s + X_ONE;
        y_d    = py_s;
        wsel_d = wsel_s;
      end
    end else begin
      x_d    = x_q;
      y_d    = y_q;
      wsel_d = wsel_q;
    end
  end

  // The sof pixel itself already uses the newly sampled mode/threshold.
  always_comb begin
    mode_d = (in_valid && in_sof) ? mode : mode_q;
`ifdef MORPH_THRESH_EN
    thr_d  = (in_valid && in_sof) ? thresh : thr_q;
`else
    thr_d  = '0;
`endif
  end

  // Counter and latched-control registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x_q    <= '0;
      y_q    <= '0;
      wsel_q <= '0;
      mode_q <= 2'b00;
      thr_q  <= '0;
    end else begin
      x_q    <= x_d;
      y_q    <= y_d;
      wsel_q <= wsel_d;
      mode_q <= mode_d;
      thr_q  <= thr_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Line RAMs: RAM (y mod NRAM) is overwritten on line y; the old word read in
  // the same cycle is row y-NRAM, the other RAMs hold rows y-1 .. y-NRAM+1.
  // ---------------------------------------------------------------------------
  logic [DATA_WIDTH-1:0] rd_s [NRAM];

  for (genvar j = 0; j < NRAM; j++) begin : g_ram
    logic [DATA_WIDTH-1:0] mem_q [IMG_WIDTH];

    assign rd_s[j] = mem_q[px_s];

    // Read-before-write line storage; contents need no reset.
    always_ff @(posedge clk) begin
      if (in_valid && (wsel_s == SW'(j))) begin
        mem_q[px_s] <= in_pixel;
      end else begin
        mem_q[px_s] <= mem_q[px_s];
      end
    end
  end

  // Row r of the window is distance KSIZE-1-r above the anchor; rows above
  // the frame top are replaced by row 0 (distance clamped to y).
  int                    dist_s [KSIZE];
  logic [SW-1:0]         ridx_s [KSIZE];
  logic [DATA_WIDTH-1:0] col_s  [KSIZE];

  // New window column, with top-edge replication.
  always_comb begin
    for (int r = 0; r < KSIZE; r++) begin
      dist_s[r] = ((KSIZE - 1 - r) > int'(py_s)) ? int'(py_s) : (KSIZE - 1 - r);
      ridx_s[r] = SW'((int'(wsel_s) + NRAM - dist_s[r]) % NRAM);
      col_s[r]  = (dist_s[r] == 32'sd0) ? in_pixel : rd_s[ridx_s[r]];
    end
  end

  // ---------------------------------------------------------------------------
  // Stage 1: tap shift registers (tap 0 newest); x==0 floods all taps.
  // ---------------------------------------------------------------------------
  logic [DATA_WIDTH-1:0] taps_q [KSIZE][KSIZE];
  logic                  v1_q, eof1_q;
  logic [1:0]            mode1_q;
  logic [DATA_WIDTH-1:0] thr1_q;

  // Window taps, advanced only on accepted pixels.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int r = 0; r < KSIZE; r++) begin
        for (int c = 0; c < KSIZE; c++) begin
          taps_q[r][c] <= '0;
        end
      end
    end else if (in_valid) begin
      for (int r = 0; r < KSIZE; r++) begin
        taps_q[r][0] <= col_s[r];
        for (int c = 1; c < KSIZE; c++) begin
          taps_q[r][c] <= (px_s == '0) ? col_s[r] : taps_q[r][c-1];
        end
      end
    end else begin
      taps_q <= taps_q;
    end
  end

  // Stage-1 sideband.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1_q    <= 1'b0;
      eof1_q  <= 1'b0;
      mode1_q <= 2'b00;
      thr1_q  <= '0;
    end else begin
      v1_q    <= in_valid;
      eof1_q  <= in_valid && last_col_s && last_row_s;
      mode1_q <= mode_d;
      thr1_q  <= thr_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Stage 2: per-row max/min
  // ---------------------------------------------------------------------------
  logic [DATA_WIDTH-1:0] rmax_s [KSIZE];
  logic [DATA_WIDTH-1:0] rmin_s [KSIZE];
  logic [DATA_WIDTH-1:0] rmax_q [KSIZE];
  logic [DATA_WIDTH-1:0] rmin_q [KSIZE];
  logic [DATA_WIDTH-1:0] pix2_q, thr2_q;
  logic                  v2_q, eof2_q;
  logic [1:0]            mode2_q;

  // Unsigned max/min over the taps of each row.
  always_comb begin
    for (int r = 0; r < KSIZE; r++) begin
      rmax_s[r] = taps_q[r][0];
      rmin_s[r] = taps_q[r][0];
      for (int c = 1; c < KSIZE; c++) begin
        rmax_s[r] = (taps_q[r][c] > rmax_s[r]) ? taps_q[r][c] : rmax_s[r];
        rmin_s[r] = (taps_q[r][c] < rmin_s[r]) ? taps_q[r][c] : rmin_s[r];
      end
    end
  end

  // Stage-2 registers; the anchor pixel is the newest tap of the bottom row.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int r = 0; r < KSIZE; r++) begin
        rmax_q[r] <= '0;
        rmin_q[r] <= '0;
      end
      pix2_q  <= '0;
      thr2_q  <= '0;
      v2_q    <= 1'b0;
      eof2_q  <= 1'b0;
      mode2_q <= 2'b00;
    end else begin
      rmax_q  <= rmax_s;
      rmin_q  <= rmin_s;
      pix2_q  <= taps_q[KSIZE-1][0];
      thr2_q  <= thr1_q;
      v2_q    <= v1_q;
      eof2_q  <= eof1_q;
      mode2_q <= mode1_q;
    end
  end

  // ---------------------------------------------------------------------------
  // Stage 3: combine rows, select mode, register outputs
  // ---------------------------------------------------------------------------
  logic [DATA_WIDTH-1:0] fmax_s, fmin_s, result_s;
  logic [DATA_WIDTH-1:0] out_pixel_q;
  logic                  out_valid_q, out_eof_q;

  // Cross-row reduction and mode mux.
  always_comb begin
    fmax_s = rmax_q[0];
    fmin_s = rmin_q[0];
    for (int r = 1; r < KSIZE; r++) begin
      fmax_s = (rmax_q[r] > fmax_s) ? rmax_q[r] : fmax_s;
      fmin_s = (rmin_q[r] < fmin_s) ? rmin_q[r] : fmin_s;
    end
    case (mode2_q)
      MODE_DILATE: result_s = fmax_s;
      MODE_ERODE:  result_s = fmin_s;
      MODE_GRAD:   result_s = fmax_s - fmin_s;
      MODE_PASS:   result_s = pix2_q;
      default:     result_s = fmax_s;
    endcase
  end

  // Output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_pixel_q <= '0;
      out_valid_q <= 1'b0;
      out_eof_q   <= 1'b0;
    end else begin
      out_pixel_q <= result_s;
      out_valid_q <= v2_q;
      out_eof_q   <= eof2_q;
    end
  end

  assign out_pixel = out_pixel_q;
  assign out_valid = out_valid_q;
  assign out_eof   = out_eof_q;

`ifdef MORPH_THRESH_EN
  logic out_bin_q;

  // Binarised result, same latency as out_pixel.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_bin_q <= 1'b0;
    end else begin
      out_bin_q <= (result_s >= thr2_q);
    end
  end

  assign out_bin = out_bin_q;
`else
  logic unused_thr_s;
  assign unused_thr_s = ^thr2_q;
`endif

endmodule

// File: tb/tb_morph_filter_nxn.sv
// -----------------------------------------------------------------------------
// tb_morph_filter_nxn
// Two instances: u_k3 (KSIZE 3, 8x4) and u_k5 (KSIZE 5, 16x8). A reference
// model recomputes each result from the stored frame image with clamped
// window bounds, and a negedge checker compares every output beat against it.
// -----------------------------------------------------------------------------
module tb_morph_filter_nxn;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  logic       iv0 = 1'b0, sof0 = 1'b0, iv1 = 1'b0, sof1 = 1'b0;
  logic [7:0] px0 = 8'h00, px1 = 8'h00;
  logic [1:0] md0 = 2'b00, md1 = 2'b00;
  logic       ov0, oe0, ov1, oe1;
  logic [7:0] op0, op1;
`ifdef MORPH_THRESH_EN
  logic [7:0] th0 = 8'h00, th1 = 8'h00;
  logic       ob0, ob1;
`endif

  morph_filter_nxn #(.DATA_WIDTH(8), .IMG_WIDTH(8), .IMG_HEIGHT(4), .KSIZE(3)) u_k3 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv0), .in_sof(sof0), .in_pixel(px0), .mode(md0),
`ifdef MORPH_THRESH_EN
    .thresh(th0), .out_bin(ob0),
`endif
    .out_valid(ov0), .out_pixel(op0), .out_eof(oe0));

  morph_filter_nxn #(.DATA_WIDTH(8), .IMG_WIDTH(16), .IMG_HEIGHT(8), .KSIZE(5)) u_k5 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv1), .in_sof(sof1), .in_pixel(px1), .mode(md1),
`ifdef MORPH_THRESH_EN
    .thresh(th1), .out_bin(ob1),
`endif
    .out_valid(ov1), .out_pixel(op1), .out_eof(oe1));

  typedef struct {
    logic [7:0] pix;
    logic       eof;
    logic       bin;
    int         due;
  } exp_t;

  exp_t       q0[$];
  exp_t       q1[$];
  logic [7:0] img [2][8][16];
  int         bx[2], by[2], mlat[2], thlat[2];
  int         cyc = 0;
  int         nvec = 0;
  int         nmis = 0;
  int         nv0 = 0, ne0 = 0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic int wof(input int d); return (d == 0) ? 8 : 16; endfunction
  function automatic int hof(input int d); return (d == 0) ? 4 : 8;  endfunction
  function automatic int kof(input int d); return (d == 0) ? 3 : 5;  endfunction

  // Reference: window rows y-K+1..y, columns x-K+1..x, negatives clamped to 0.
  function automatic logic [7:0] model(input int d, input int x, input int y, input int m);
    int k; int cy; int cx;
    logic [7:0] mx, mn, v;
    k = kof(d); mx = 8'h00; mn = 8'hFF;
    for (int yy = y - k + 1; yy <= y; yy++) begin
      for (int xx = x - k + 1; xx <= x; xx++) begin
        cy = (yy < 0) ? 0 : yy;
        cx = (xx < 0) ? 0 : xx;
        v  = img[d][cy][cx];
        if (v > mx) mx = v;
        if (v < mn) mn = v;
      end
    end
    case (m)
      0:       return mx;
      1:       return mn;
      2:       return mx - mn;
      default: return img[d][y][x];
    endcase
  endfunction

  function automatic logic [7:0] pixgen(input int kind, input int x, input int y);
    case (kind)
      0:       return 8'h40;
      1:       return (x == 3 && y == 2) ? 8'hFF : 8'h10;
      2:       return ((x + y) % 2 == 1) ? 8'hC8 : 8'h00;
      3:       return 8'(x + 8 * y);
      4:       return 8'(x * 16 + y + 1);
      default: return ((x + y) % 2 == 1) ? 8'h81 : 8'h7F;
    endcase
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
    nvec++;
    if (act !== want) begin
      nmis++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, want, cyc);
    end
  endtask

  task automatic idle();
    @(posedge clk); #1;
    iv0 = 1'b0; sof0 = 1'b0; iv1 = 1'b0; sof1 = 1'b0;
  endtask

  task automatic drive(input int d, input logic [7:0] pix, input logic sof,
                       input logic [1:0] m, input logic [7:0] th);
    exp_t e; int x; int y;
    @(posedge clk); #1;
    iv0 = 1'b0; sof0 = 1'b0; iv1 = 1'b0; sof1 = 1'b0;
    if (d == 0) begin iv0 = 1'b1; sof0 = sof; px0 = pix; md0 = m; end
    else        begin iv1 = 1'b1; sof1 = sof; px1 = pix; md1 = m; end
`ifdef MORPH_THRESH_EN
    if (d == 0) th0 = th; else th1 = th;
`endif
    x = sof ? 0 : bx[d];
    y = sof ? 0 : by[d];
    if (sof) begin mlat[d] = int'(m); thlat[d] = int'(th); end
    img[d][y][x] = pix;
    e.pix = model(d, x, y, mlat[d]);
    e.eof = (x == wof(d) - 1) && (y == hof(d) - 1);
    e.bin = (int'(e.pix) >= thlat[d]);
    e.due = cyc + 3;
    if (d == 0) q0.push_back(e); else q1.push_back(e);
    bx[d] = (x == wof(d) - 1) ? 0 : x + 1;
    by[d] = (x == wof(d) - 1) ? ((y == hof(d) - 1) ? 0 : y + 1) : y;
  endtask

  // Whole (or truncated) frame; mode input switches to m1 at pixel switch_at.
  task automatic frame(input int d, input int kind, input logic [1:0] m0, input logic [1:0] m1,
                       input int switch_at, input int gap, input logic use_sof, input int stop_at);
    for (int i = 0; i < wof(d) * hof(d) && i < stop_at; i++) begin
      drive(d, pixgen(kind, i % wof(d), i / wof(d)), use_sof && (i == 0),
            (i < switch_at) ? m0 : m1, 8'h80);
      repeat (gap) idle();
    end
  endtask

  task automatic cmp(input int d, input logic v, input logic [7:0] p, input logic e, input logic b);
    exp_t ex; logic have;
    have = 1'b0;
    if (d == 0) begin
      if (q0.size() > 0 && q0[0].due == cyc) begin ex = q0.pop_front(); have = 1'b1; end
    end else begin
      if (q1.size() > 0 && q1[0].due == cyc) begin ex = q1.pop_front(); have = 1'b1; end
    end
    if (have) begin
      chk($sformatf("u%0d out_valid", d), {31'd0, v}, 32'd1);
      chk($sformatf("u%0d out_pixel", d), {24'd0, p}, {24'd0, ex.pix});
      chk($sformatf("u%0d out_eof", d), {31'd0, e}, {31'd0, ex.eof});
`ifdef MORPH_THRESH_EN
      chk($sformatf("u%0d out_bin", d), {31'd0, b}, {31'd0, ex.bin});
`endif
    end else if (v !== 1'b0) begin
      chk($sformatf("u%0d spurious out_valid", d), {31'd0, v}, 32'd0);
    end
  endtask

  // Per-cycle compare against the model, away from the active edge.
  always @(negedge clk) begin
    if (rst_n) begin
`ifdef MORPH_THRESH_EN
      cmp(0, ov0, op0, oe0, ob0);
      cmp(1, ov1, op1, oe1, ob1);
`else
      cmp(0, ov0, op0, oe0, 1'b0);
      cmp(1, ov1, op1, oe1, 1'b0);
`endif
      if (ov0) nv0++;
      if (ov0 && oe0) ne0++;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int d = 0; d < 2; d++) begin bx[d] = 0; by[d] = 0; mlat[d] = 0; thlat[d] = 0; end
    #2 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset u0 out_valid", {31'd0, ov0}, 32'd0);
    chk("reset u0 out_pixel", {24'd0, op0}, 32'd0);
    chk("reset u0 out_eof",   {31'd0, oe0}, 32'd0);
    chk("reset u1 out_valid", {31'd0, ov1}, 32'd0);
    chk("reset u1 out_pixel", {24'd0, op1}, 32'd0);
    rst_n = 1'b1;

    // Flat frame: 32 results of 0x40, eof only on the last.
    nv0 = 0; ne0 = 0;
    frame(0, 0, 2'b00, 2'b00, 999, 0, 1'b1, 999);
    chk("pin flat (5,2)", {24'd0, model(0, 5, 2, 0)}, 32'h40);
    repeat (5) idle();
    chk("flat out_valid count", nv0, 32);
    chk("flat out_eof count", ne0, 1);

    // Single peak, dilate then erode back-to-back.
    frame(0, 1, 2'b00, 2'b00, 999, 0, 1'b1, 999);
    chk("pin peak dilate (4,3)", {24'd0, model(0, 4, 3, 0)}, 32'hFF);
    chk("pin peak dilate (5,2)", {24'd0, model(0, 5, 2, 0)}, 32'hFF);
    chk("pin peak dilate (6,2)", {24'd0, model(0, 6, 2, 0)}, 32'h10);
    chk("pin peak dilate (3,1)", {24'd0, model(0, 3, 1, 0)}, 32'h10);
    frame(0, 1, 2'b01, 2'b01, 999, 0, 1'b1, 999);
    chk("pin peak erode (4,3)", {24'd0, model(0, 4, 3, 1)}, 32'h10);

    // Gradient on checkerboard; mode input changes to dilate mid-frame.
    frame(0, 2, 2'b10, 2'b00, 13, 0, 1'b1, 999);
    chk("pin gradient (3,2)", {24'd0, model(0, 3, 2, 2)}, 32'hC8);
    frame(0, 2, 2'b00, 2'b00, 999, 0, 1'b1, 999);

    // Edge replication, KSIZE 5 erode on a ramp.
    frame(1, 3, 2'b01, 2'b01, 999, 0, 1'b1, 999);
    chk("pin ramp erode (0,0)", {24'd0, model(1, 0, 0, 1)}, 32'h00);
    chk("pin ramp erode (2,1)", {24'd0, model(1, 2, 1, 1)}, 32'h00);
    chk("pin ramp erode (6,5)", {24'd0, model(1, 6, 5, 1)}, 32'h0A);
    repeat (4) idle();

    // Gapped input, 1-in-3 duty.
    frame(0, 1, 2'b00, 2'b00, 999, 2, 1'b1, 999);

    // Reset in the middle of a passthrough frame.
    frame(0, 4, 2'b11, 2'b11, 999, 0, 1'b1, 12);
    #2 rst_n = 1'b0;
    #1;
    chk("midreset out_valid", {31'd0, ov0}, 32'd0);
    chk("midreset out_pixel", {24'd0, op0}, 32'd0);
    chk("midreset out_eof",   {31'd0, oe0}, 32'd0);
    iv0 = 1'b0; sof0 = 1'b0;
    q0.delete();
    bx[0] = 0; by[0] = 0; mlat[0] = 0; thlat[0] = 0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    // No sof: starts at (0,0) with the reset mode (dilate).
    frame(0, 4, 2'b11, 2'b11, 999, 0, 1'b0, 999);

    // Threshold image 0x7F/0x81, dilate, thresh 0x80.
    frame(0, 5, 2'b00, 2'b00, 999, 0, 1'b1, 999);

    repeat (8) idle();
    chk("drain u0 queue", q0.size(), 0);
    chk("drain u1 queue", q1.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule
